tl_periph_router: RTL and testbench
===================================

TL_PERIPH_ROUTER -- requirements
Module: tl_periph_router

Interface
REQ-001 TL_RS, default 4, TileLink source-ID width.
REQ-002 S0_BASE, default 32'h0200_0000, port-0 (timer/software-interrupt slave) base address.
REQ-003 S0_MASK, default 32'hFFFF_0000, port-0 decode mask (64 KiB window).
REQ-004 S1_BASE, default 32'h0C00_0000, port-1 base address.
REQ-005 S1_MASK, default 32'hFC00_0000, port-1 decode mask.
REQ-006 DEPTH, default 4, route-FIFO depth; power of two, at least 2.
REQ-007 tlr_clock_i  in  1  single clock; all state updates on its rising edge.
REQ-008 tlr_reset_ni  in  1  synchronous active-low reset.
REQ-009 m_a_{opcode,param,size,source,address,mask,data,valid}  in  3/3/4/TL_RS/32/4/32/1  upstream TileLink-UH A channel.
REQ-010 m_a_ready  out  1  A-channel accept.
REQ-011 m_d_{opcode,param,size,source,denied,data,corrupt,valid}  out  3/2/4/TL_RS/1/32/1/1  upstream D channel.
REQ-012 m_d_ready  in  1  D-channel accept.
REQ-013 s0_a_* / s1_a_*  out  same widths as m_a_* except s0_a_address is 16 bits; sN_a_ready in, 1 bit.
REQ-014 s0_d_* / s1_d_*  in  same widths as m_d_*; sN_d_ready out, 1 bit.

Function
REQ-015 Decode: hit0 = (m_a_address & S0_MASK)==S0_BASE; hit1 likewise; hit0 wins if both; neither, or m_a_size>2, is an error request.
REQ-016 A fire = m_a_valid & m_a_ready; all requests are single-beat.
REQ-017 m_a_ready = !full & (hit0 ? s0_a_ready : hit1 ? s1_a_ready : 1); error requests are absorbed internally.
REQ-018 sN_a_valid = m_a_valid & selected-N & !full; payload passes combinationally; s0_a_address = m_a_address[15:0]; s1_a_address = full 32 bits.
REQ-019 Every A fire pushes one route entry: port (0, 1, 2=error), opcode, size, source.
REQ-020 When full, m_a_ready = 0 and no sN_a_valid is asserted, even on a same-cycle pop (no bypass).
REQ-021 D path is combinational from the FIFO head; m_d_valid = 0 when the FIFO is empty.
REQ-022 Head port N: m_d_* = sN_d_*; sN_d_ready = m_d_ready; the other slave's d_ready = 0, stalling out-of-order beats.
REQ-023 Head port error: m_d_valid = 1; m_d_opcode = 1 (AccessAckData) for stored opcode 4 (Get), else 0 (AccessAck); m_d_denied = 1; m_d_corrupt = 1 only for AccessAckData; m_d_data = 0; m_d_param = 0; size and source from the entry.
REQ-024 Pop on m_d fire; an error entry completes in one cycle once m_d_ready = 1.
REQ-025 Simultaneous push and pop when not full: count unchanged, both pointers advance.
REQ-026 Pointers wrap modulo DEPTH; count ranges 0..DEPTH; full = (count==DEPTH); empty = (count==0).
REQ-027 Requests complete in issue order; responses carry no reordering or source remapping.

Reset
REQ-028 While tlr_reset_ni = 0 at a clock edge: read/write pointers = 0 and count = 0.
REQ-029 During and after reset until a push: m_d_valid = 0, s0_a_valid = 0, s1_a_valid = 0, s0_d_ready = 0, s1_d_ready = 0.
REQ-030 Reset mid-transaction discards all outstanding route entries; late slave D beats are not forwarded (sN_d_ready = 0 while empty).

Verification
REQ-031 Get to 32'h0200_BFF8, size 2, source 3; s0 returns opcode 1, data 32'h1234 -> s0_a_address = 16'hBFF8 and m_d matches source 3, denied 0.
REQ-032 PutFullData to 32'h0000_1000, source 5 -> no sN_a_valid; next m_d: opcode 0, denied 1, corrupt 0, source 5. Get to the same address -> opcode 1, denied 1, corrupt 1, data 0.
REQ-033 Put to s1, then Get to s0 issued back-to-back; s0 responds first -> s0_d_ready held at 0 until s1's beat is forwarded; upstream order is s1 then s0.
REQ-034 Issue DEPTH requests with m_d_ready = 0 -> m_a_ready = 0 on the (DEPTH+1)th; raise m_d_ready for one beat -> exactly one more request is accepted the following cycle.
REQ-035 Hold tlr_reset_ni = 0 for one edge with 2 entries outstanding -> count = 0, m_d_valid = 0; a subsequent Get completes normally.
REQ-036 Get with size 3 to a port-0 address -> routed to error; denied response returned; s0_a_valid never asserted.

Source files
------------

// File: rtl/tl_periph_router_if.sv
`default_nettype none
// ============================================================================
// Module      : tl_periph_router_if
// Description : TileLink-UH single-beat A/D channel bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface tl_periph_router_if #(
    parameter int TL_RS = 4,
    parameter int AW    = 32
) ();
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [3:0]       a_size;
    logic [TL_RS-1:0] a_source;
    logic [AW-1:0]    a_address;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;
    logic             a_valid;
    logic             a_ready;

    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [3:0]       d_size;
    logic [TL_RS-1:0] d_source;
    logic             d_denied;
    logic [31:0]      d_data;
    logic             d_corrupt;
    logic             d_valid;
    logic             d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
        input  a_ready,
        input  d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
        output d_ready
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid,
        output a_ready,
        output d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt, d_valid,
        input  d_ready
    );
endinterface
`default_nettype wire

// File: rtl/tl_periph_router.sv
`default_nettype none
// ============================================================================
// Module      : tl_periph_router
// Description : 1:2 TileLink-UH address router with in-order route FIFO and
//               internal denied responder for undecoded/oversized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_periph_router #(
    parameter int          TL_RS   = 4,
    parameter logic [31:0] S0_BASE = 32'h0200_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h0C00_0000,
    parameter logic [31:0] S1_MASK = 32'hFC00_0000,
    parameter int          DEPTH   = 4
) (
    input wire                 tlr_clock_i,
    input wire                 tlr_reset_ni,
    tl_periph_router_if.slave  m,
    tl_periph_router_if.master s0,
    tl_periph_router_if.master s1
);

    localparam int               c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT  = DEPTH[c_PTR_W:0];
    localparam logic [1:0]       c_PORT_S0   = 2'd0;
    localparam logic [1:0]       c_PORT_S1   = 2'd1;
    localparam logic [1:0]       c_PORT_ERR  = 2'd2;
    localparam logic [2:0]       c_OP_GET    = 3'd4;
    localparam logic [2:0]       c_D_ACK     = 3'd0;
    localparam logic [2:0]       c_D_ACKDATA = 3'd1;

    logic [1:0]       r_port   [DEPTH];
    logic [2:0]       r_opcode [DEPTH];
    logic [3:0]       r_size   [DEPTH];
    logic [TL_RS-1:0] r_source [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;

    logic       w_full, w_empty;
    logic       w_hit0, w_hit1, w_size_ok, w_sel0, w_sel1;
    logic [1:0] w_sel_port;
    logic       w_a_ready, w_d_valid, w_push, w_pop;
    logic [1:0] w_head_port;
    logic       w_head_get;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // hit0 has priority; oversized accesses are denied even on a decode hit
    assign w_hit0     = ((m.a_address & S0_MASK) == S0_BASE);
    assign w_hit1     = ((m.a_address & S1_MASK) == S1_BASE);
    assign w_size_ok  = (m.a_size <= 4'd2);
    assign w_sel0     = w_hit0 & w_size_ok;
    assign w_sel1     = !w_hit0 & w_hit1 & w_size_ok;
    assign w_sel_port = w_sel0 ? c_PORT_S0 : (w_sel1 ? c_PORT_S1 : c_PORT_ERR);

    assign w_a_ready = !w_full & (w_sel0 ? s0.a_ready : (w_sel1 ? s1.a_ready : 1'b1));
    assign m.a_ready = w_a_ready;
    assign w_push    = m.a_valid & w_a_ready;

    assign s0.a_valid   = m.a_valid & w_sel0 & !w_full;
    assign s0.a_opcode  = m.a_opcode;
    assign s0.a_param   = m.a_param;
    assign s0.a_size    = m.a_size;
    assign s0.a_source  = m.a_source;
    assign s0.a_address = m.a_address[15:0];
    assign s0.a_mask    = m.a_mask;
    assign s0.a_data    = m.a_data;

    assign s1.a_valid   = m.a_valid & w_sel1 & !w_full;
    assign s1.a_opcode  = m.a_opcode;
    assign s1.a_param   = m.a_param;
    assign s1.a_size    = m.a_size;
    assign s1.a_source  = m.a_source;
    assign s1.a_address = m.a_address;
    assign s1.a_mask    = m.a_mask;
    assign s1.a_data    = m.a_data;

    assign w_head_port = r_port[r_rptr];
    assign w_head_get  = (r_opcode[r_rptr] == c_OP_GET);

    // The slave not at the FIFO head keeps d_ready low so its beat waits its turn
    always_comb begin
        w_d_valid   = 1'b0;
        m.d_opcode  = 3'd0;
        m.d_param   = 2'd0;
        m.d_size    = 4'd0;
        m.d_source  = '0;
        m.d_denied  = 1'b0;
        m.d_data    = 32'd0;
        m.d_corrupt = 1'b0;
        s0.d_ready  = 1'b0;
        s1.d_ready  = 1'b0;
        if (!w_empty) begin
            unique case (w_head_port)
                c_PORT_S0: begin
                    w_d_valid   = s0.d_valid;
                    m.d_opcode  = s0.d_opcode;
                    m.d_param   = s0.d_param;
                    m.d_size    = s0.d_size;
                    m.d_source  = s0.d_source;
                    m.d_denied  = s0.d_denied;
                    m.d_data    = s0.d_data;
                    m.d_corrupt = s0.d_corrupt;
                    s0.d_ready  = m.d_ready;
                end
                c_PORT_S1: begin
                    w_d_valid   = s1.d_valid;
                    m.d_opcode  = s1.d_opcode;
                    m.d_param   = s1.d_param;
                    m.d_size    = s1.d_size;
                    m.d_source  = s1.d_source;
                    m.d_denied  = s1.d_denied;
                    m.d_data    = s1.d_data;
                    m.d_corrupt = s1.d_corrupt;
                    s1.d_ready  = m.d_ready;
                end
                default: begin
                    w_d_valid   = 1'b1;
                    m.d_opcode  = w_head_get ? c_D_ACKDATA : c_D_ACK;
                    m.d_size    = r_size[r_rptr];
                    m.d_source  = r_source[r_rptr];
                    m.d_denied  = 1'b1;
                    m.d_corrupt = w_head_get;
                end
            endcase
        end
    end

    assign m.d_valid = w_d_valid;
    assign w_pop     = w_d_valid & m.d_ready;

    always_ff @(posedge tlr_clock_i) begin
        if (!tlr_reset_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge tlr_clock_i) begin
        if (w_push) begin
            r_port[r_wptr]   <= w_sel_port;
            r_opcode[r_wptr] <= m.a_opcode;
            r_size[r_wptr]   <= m.a_size;
            r_source[r_wptr] <= m.a_source;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tl_periph_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_periph_router
// Description : Directed vector bench for tl_periph_router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_periph_router;

    localparam int c_RS    = 4;
    localparam int c_DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    tl_periph_router_if #(.TL_RS(c_RS), .AW(32)) m_if ();
    tl_periph_router_if #(.TL_RS(c_RS), .AW(16)) s0_if ();
    tl_periph_router_if #(.TL_RS(c_RS), .AW(32)) s1_if ();

    tl_periph_router #(.TL_RS(c_RS), .DEPTH(c_DEPTH)) dut (
        .tlr_clock_i  (clk),
        .tlr_reset_ni (rst_n),
        .m            (m_if),
        .s0           (s0_if),
        .s1           (s1_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [3:0]  src;
        logic [31:0] addr;
        logic [1:0]  port;
        logic [2:0]  d_op;
        logic        denied;
        logic        corrupt;
        logic [31:0] d_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [3:0] size,
                           input logic [3:0] src, input logic [31:0] addr);
        m_if.a_valid   = 1'b1;
        m_if.a_opcode  = op;
        m_if.a_param   = 3'd0;
        m_if.a_size    = size;
        m_if.a_source  = src;
        m_if.a_address = addr;
        m_if.a_mask    = 4'hF;
        m_if.a_data    = 32'h5A5A_0000 | 32'(src);
    endtask

    task automatic s0_resp(input logic v, input logic [2:0] op, input logic [3:0] src,
                           input logic [31:0] data);
        s0_if.d_valid = v; s0_if.d_opcode = op; s0_if.d_param = 2'd0; s0_if.d_size = 4'd2;
        s0_if.d_source = src; s0_if.d_denied = 1'b0; s0_if.d_data = data; s0_if.d_corrupt = 1'b0;
    endtask

    task automatic s1_resp(input logic v, input logic [2:0] op, input logic [3:0] src,
                           input logic [31:0] data);
        s1_if.d_valid = v; s1_if.d_opcode = op; s1_if.d_param = 2'd0; s1_if.d_size = 4'd2;
        s1_if.d_source = src; s1_if.d_denied = 1'b0; s1_if.d_data = data; s1_if.d_corrupt = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //            op    size  src   addr           port  d_op  den  cor  d_data
        vecs[0] = '{3'd4, 4'd2, 4'd3, 32'h0200_BFF8, 2'd0, 3'd1, 1'b0, 1'b0, 32'h0000_1234};
        vecs[1] = '{3'd0, 4'd2, 4'd5, 32'h0000_1000, 2'd2, 3'd0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2] = '{3'd4, 4'd2, 4'd6, 32'h0000_1000, 2'd2, 3'd1, 1'b1, 1'b1, 32'h0000_0000};
        vecs[3] = '{3'd0, 4'd2, 4'd7, 32'h0C00_0040, 2'd1, 3'd0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[4] = '{3'd4, 4'd3, 4'd2, 32'h0200_0010, 2'd2, 3'd1, 1'b1, 1'b1, 32'h0000_0000};
        vecs[5] = '{3'd4, 4'd2, 4'd9, 32'h0FFF_FFFC, 2'd1, 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[6] = '{3'd1, 4'd2, 4'd4, 32'h0201_0000, 2'd2, 3'd0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[7] = '{3'd4, 4'd0, 4'd15, 32'h0200_FFFF, 2'd0, 3'd1, 1'b0, 1'b0, 32'h0000_00AB};
        vecs[8] = '{3'd4, 4'd2, 4'd1, 32'h1000_0000, 2'd2, 3'd1, 1'b1, 1'b1, 32'h0000_0000};

        rst_n = 1'b0;
        drive_a(3'd0, 4'd0, 4'd0, 32'd0);
        m_if.a_valid = 1'b0;
        m_if.d_ready = 1'b0;
        s0_if.a_ready = 1'b1;
        s1_if.a_ready = 1'b1;
        s0_resp(1'b0, 3'd0, 4'd0, 32'd0);
        s1_resp(1'b0, 3'd0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst m_d_valid", 32'(m_if.d_valid), 32'd0);
        chk("rst s0_a_valid", 32'(s0_if.a_valid), 32'd0);
        chk("rst s1_a_valid", 32'(s1_if.a_valid), 32'd0);
        chk("rst s0_d_ready", 32'(s0_if.d_ready), 32'd0);
        chk("rst s1_d_ready", 32'(s1_if.d_ready), 32'd0);
        rst_n = 1'b1;
        m_if.d_ready = 1'b1;

        // Table: decode check, accept, then response check and drain
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_a(vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr);
            #1;
            chk($sformatf("v%0d a_ready", i), 32'(m_if.a_ready), 32'd1);
            chk($sformatf("v%0d s0_a_valid", i), 32'(s0_if.a_valid), 32'(vecs[i].port == 2'd0));
            chk($sformatf("v%0d s1_a_valid", i), 32'(s1_if.a_valid), 32'(vecs[i].port == 2'd1));
            if (vecs[i].port == 2'd0)
                chk($sformatf("v%0d s0_addr", i), 32'(s0_if.a_address), 32'(vecs[i].addr[15:0]));
            if (vecs[i].port == 2'd1)
                chk($sformatf("v%0d s1_addr", i), s1_if.a_address, vecs[i].addr);
            @(posedge clk);
            @(negedge clk);
            m_if.a_valid = 1'b0;
            if (vecs[i].port == 2'd0) s0_resp(1'b1, vecs[i].d_op, vecs[i].src, vecs[i].d_data);
            if (vecs[i].port == 2'd1) s1_resp(1'b1, vecs[i].d_op, vecs[i].src, vecs[i].d_data);
            #1;
            chk($sformatf("v%0d d_valid", i), 32'(m_if.d_valid), 32'd1);
            chk($sformatf("v%0d d_opcode", i), 32'(m_if.d_opcode), 32'(vecs[i].d_op));
            chk($sformatf("v%0d d_denied", i), 32'(m_if.d_denied), 32'(vecs[i].denied));
            chk($sformatf("v%0d d_corrupt", i), 32'(m_if.d_corrupt), 32'(vecs[i].corrupt));
            chk($sformatf("v%0d d_data", i), m_if.d_data, vecs[i].d_data);
            chk($sformatf("v%0d d_source", i), 32'(m_if.d_source), 32'(vecs[i].src));
            chk($sformatf("v%0d d_param", i), 32'(m_if.d_param), 32'd0);
            if (vecs[i].port == 2'd2)
                chk($sformatf("v%0d d_size", i), 32'(m_if.d_size), 32'(vecs[i].size));
            chk($sformatf("v%0d s0_d_ready", i), 32'(s0_if.d_ready), 32'(vecs[i].port == 2'd0));
            chk($sformatf("v%0d s1_d_ready", i), 32'(s1_if.d_ready), 32'(vecs[i].port == 2'd1));
            @(posedge clk);
            @(negedge clk);
            s0_resp(1'b0, 3'd0, 4'd0, 32'd0);
            s1_resp(1'b0, 3'd0, 4'd0, 32'd0);
            #1;
            chk($sformatf("v%0d drained", i), 32'(m_if.d_valid), 32'd0);
        end

        // Ordering: s1 request then s0 request; s0 answers first and must wait
        @(negedge clk);
        drive_a(3'd0, 4'd2, 4'd1, 32'h0C00_0000);
        @(posedge clk);
        @(negedge clk);
        drive_a(3'd4, 4'd2, 4'd2, 32'h0200_0000);
        @(posedge clk);
        @(negedge clk);
        m_if.a_valid = 1'b0;
        s0_resp(1'b1, 3'd1, 4'd2, 32'h0000_5555);
        #1;
        chk("ord s0_d_ready held", 32'(s0_if.d_ready), 32'd0);
        chk("ord m_d_valid idle", 32'(m_if.d_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("ord s0_d_ready held2", 32'(s0_if.d_ready), 32'd0);
        s1_resp(1'b1, 3'd0, 4'd1, 32'd0);
        #1;
        chk("ord first valid", 32'(m_if.d_valid), 32'd1);
        chk("ord first source", 32'(m_if.d_source), 32'd1);
        chk("ord s1_d_ready", 32'(s1_if.d_ready), 32'd1);
        chk("ord s0_d_ready still", 32'(s0_if.d_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s1_resp(1'b0, 3'd0, 4'd0, 32'd0);
        #1;
        chk("ord second source", 32'(m_if.d_source), 32'd2);
        chk("ord second data", m_if.d_data, 32'h0000_5555);
        chk("ord s0_d_ready now", 32'(s0_if.d_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s0_resp(1'b0, 3'd0, 4'd0, 32'd0);
        #1;
        chk("ord drained", 32'(m_if.d_valid), 32'd0);

        // Full FIFO: DEPTH error requests with responses stalled
        m_if.d_ready = 1'b0;
        for (int k = 0; k < c_DEPTH; k++) begin
            @(negedge clk);
            drive_a(3'd0, 4'd2, 4'(k), 32'h0000_1000);
            #1;
            chk($sformatf("fill%0d a_ready", k), 32'(m_if.a_ready), 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        drive_a(3'd4, 4'd2, 4'd8, 32'h0200_0100);
        #1;
        chk("full a_ready", 32'(m_if.a_ready), 32'd0);
        chk("full s0_a_valid", 32'(s0_if.a_valid), 32'd0);
        m_if.d_ready = 1'b1;
        #1;
        chk("full no bypass", 32'(m_if.a_ready), 32'd0);
        chk("full head source", 32'(m_if.d_source), 32'd0);
        @(posedge clk);
        @(negedge clk);
        m_if.d_ready = 1'b0;
        #1;
        chk("after pop a_ready", 32'(m_if.a_ready), 32'd1);
        chk("after pop s0_a_valid", 32'(s0_if.a_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive_a(3'd4, 4'd2, 4'd9, 32'h0200_0104);
        #1;
        chk("refull a_ready", 32'(m_if.a_ready), 32'd0);
        m_if.a_valid = 1'b0;
        m_if.d_ready = 1'b1;
        for (int k = 1; k < c_DEPTH; k++) begin
            #1;
            chk($sformatf("drain%0d valid", k), 32'(m_if.d_valid), 32'd1);
            chk($sformatf("drain%0d source", k), 32'(m_if.d_source), 32'(k));
            @(posedge clk);
            @(negedge clk);
        end
        s0_resp(1'b1, 3'd1, 4'd8, 32'h0000_0077);
        #1;
        chk("drain last source", 32'(m_if.d_source), 32'd8);
        chk("drain last denied", 32'(m_if.d_denied), 32'd0);
        @(posedge clk);
        @(negedge clk);
        s0_resp(1'b0, 3'd0, 4'd0, 32'd0);
        #1;
        chk("drain empty", 32'(m_if.d_valid), 32'd0);

        // Reset with two entries outstanding
        m_if.d_ready = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            drive_a(3'd4, 4'd2, 4'(k), 32'h0000_2000);
            @(posedge clk);
        end
        @(negedge clk);
        m_if.a_valid = 1'b0;
        #1;
        chk("pre-rst d_valid", 32'(m_if.d_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_if.d_ready = 1'b1;
        s0_resp(1'b1, 3'd1, 4'd3, 32'h0000_0BAD);
        #1;
        chk("post-rst d_valid", 32'(m_if.d_valid), 32'd0);
        chk("post-rst s0_d_ready", 32'(s0_if.d_ready), 32'd0);
        chk("post-rst s1_d_ready", 32'(s1_if.d_ready), 32'd0);
        s0_resp(1'b0, 3'd0, 4'd0, 32'd0);
        drive_a(3'd4, 4'd2, 4'd4, 32'h0200_0008);
        #1;
        chk("post-rst s0_a_valid", 32'(s0_if.a_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        m_if.a_valid = 1'b0;
        s0_resp(1'b1, 3'd1, 4'd4, 32'h0000_CAFE);
        #1;
        chk("post-rst resp valid", 32'(m_if.d_valid), 32'd1);
        chk("post-rst resp source", 32'(m_if.d_source), 32'd4);
        chk("post-rst resp data", m_if.d_data, 32'h0000_CAFE);
        @(posedge clk);
        @(negedge clk);
        s0_resp(1'b0, 3'd0, 4'd0, 32'd0);
        #1;
        chk("post-rst empty", 32'(m_if.d_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
